// File: rtl/wb_print_pkg.sv
// Shared constants for the Wishbone print FIFO: register map and STATUS bit layout.
package wb_print_pkg;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_EXIT   = 2'd2;

    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_OVF   = 18;

endpackage

// File: rtl/wb_print_fifo_mem.sv
// Byte-wide synchronous FIFO with a registered head output.
// The caller guarantees push only when there is room (or a pop in the same cycle)
// and pop only when non-empty.
module wb_print_fifo_mem #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    head_q, head_d;

    // Next pointers, fill level and head byte; the head is looked up at the
    // next read pointer so the registered head always matches the FIFO front.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !push)
            count_d = count_q - (AW+1)'(1);
        // The slot being written this cycle is the next head only when the
        // FIFO was empty, or held one entry that is popping now.
        if (count_d == '0)
            head_d = 8'h00;
        else if (push && (wr_ptr_q == rd_ptr_d))
            head_d = wdata;
        else
            head_d = mem_q[rd_ptr_d];
    end

    // Storage array: written on push, no reset needed.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= wdata;
    end

    // Pointer, level and head registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head  = head_q;
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/wb_print_fifo.sv
// Wishbone character-output peripheral: CPU bytes are queued in a TX FIFO and
// drained over a paced valid/ready byte stream. Also exposes STATUS and a
// sticky test-exit register for the simulation harness.
module wb_print_fifo
    import wb_print_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int PACE          = 0,
    parameter int STALL_ON_FULL = 1,
    parameter int SIM_PRINT     = 1
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_halt,
    output logic [7:0]  o_exit_code
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (PACE > 0) ? $clog2(PACE + 1) : 1;

    logic          ack_q, ack_d;
    logic [31:0]   rdt_q, rdt_d;
    logic          ovf_q, ovf_d;
    logic          halt_q, halt_d;
    logic [7:0]    code_q, code_d;
    logic [PW-1:0] pace_q, pace_d;

    logic          req, wr_data, room, stall, fire, push, pop, tx_valid;
    logic          full, empty;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic [31:0]   status;
    wire           unused_dat = ^{i_wb_dat[31:19], i_wb_dat[17:8]};

    wb_print_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (i_wb_clk),
        .rst   (i_wb_rst),
        .push  (push),
        .pop   (pop),
        .wdata (i_wb_dat[7:0]),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // A request is taken only while ack is low, so acks never run back to back.
    // A DATA write into a full FIFO can still land when a pop frees the slot
    // in the same cycle.
    assign req      = i_wb_cyc && i_wb_stb && !ack_q;
    assign wr_data  = req && i_wb_we && (i_wb_adr == ADR_DATA);
    assign tx_valid = !empty && (pace_q == '0);
    assign pop      = tx_valid && i_tx_ready;
    assign room     = !full || pop;
    assign stall    = wr_data && !room && (STALL_ON_FULL != 0);
    assign fire     = req && !stall;
    assign push     = fire && wr_data && room;

    // STATUS word assembled from the live FIFO state.
    always_comb begin
        status           = '0;
        status[8:0]      = 9'(count);
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_OVF]   = ovf_q;
    end

    // Bus decode: ack, read data and register side effects of the accepted request.
    always_comb begin
        ack_d  = fire;
        rdt_d  = '0;
        ovf_d  = ovf_q;
        halt_d = halt_q;
        code_d = code_q;
        if (fire && !i_wb_we && (i_wb_adr == ADR_STATUS))
            rdt_d = status;
        if (fire && wr_data && !room)
            ovf_d = 1'b1;
        if (fire && i_wb_we && (i_wb_adr == ADR_STATUS) && i_wb_dat[ST_OVF])
            ovf_d = 1'b0;
        if (fire && i_wb_we && (i_wb_adr == ADR_EXIT) && !halt_q) begin
            halt_d = 1'b1;
            code_d = i_wb_dat[7:0];
        end
    end

    // Pacing: each beat reloads the idle counter, which counts down to 0.
    always_comb begin
        pace_d = pace_q;
        if (pop)
            pace_d = PW'(PACE);
        else if (pace_q != '0)
            pace_d = pace_q - PW'(1);
    end

    // Bus, exit and pacing registers, cleared asynchronously.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            ack_q  <= 1'b0;
            rdt_q  <= '0;
            ovf_q  <= 1'b0;
            halt_q <= 1'b0;
            code_q <= 8'h00;
            pace_q <= '0;
        end else begin
            ack_q  <= ack_d;
            rdt_q  <= rdt_d;
            ovf_q  <= ovf_d;
            halt_q <= halt_d;
            code_q <= code_d;
            pace_q <= pace_d;
        end
    end

    assign o_wb_ack    = ack_q;
    assign o_wb_rdt    = rdt_q;
    assign o_tx_valid  = tx_valid;
    assign o_tx_data   = head;
    assign o_halt      = halt_q;
    assign o_exit_code = code_q;

`ifndef SYNTHESIS
    // Echo each drained byte to the console.
    always @(posedge i_wb_clk) begin
        if ((SIM_PRINT != 0) && pop)
            $write("%c", head);
    end
`endif

endmodule

// File: tb/tb_wb_print_fifo.sv
// Scoreboard bench for wb_print_fifo: three instances (stall, drop, paced)
// share one clock/reset; expected stream bytes and read data are queued at
// issue time and checked by a monitor when the DUT presents them.
`timescale 1ns/1ps
module tb_wb_print_fifo;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  adr   [N];
    logic [31:0] dat   [N];
    logic        we    [N];
    logic        cyc   [N];
    logic        stb   [N];
    logic        ready [N];
    logic [31:0] rdt   [N];
    logic        ack   [N];
    logic        txv   [N];
    logic [7:0]  txd   [N];
    logic        halt  [N];
    logic [7:0]  code  [N];

    always #5 clk = ~clk;

    wb_print_fifo #(.DEPTH(4), .PACE(0), .STALL_ON_FULL(1), .SIM_PRINT(0)) u_stall (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(adr[0]), .i_wb_dat(dat[0]),
        .i_wb_we(we[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .o_wb_rdt(rdt[0]),
        .o_wb_ack(ack[0]), .o_tx_valid(txv[0]), .o_tx_data(txd[0]),
        .i_tx_ready(ready[0]), .o_halt(halt[0]), .o_exit_code(code[0]));

    wb_print_fifo #(.DEPTH(4), .PACE(0), .STALL_ON_FULL(0), .SIM_PRINT(0)) u_drop (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(adr[1]), .i_wb_dat(dat[1]),
        .i_wb_we(we[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .o_wb_rdt(rdt[1]),
        .o_wb_ack(ack[1]), .o_tx_valid(txv[1]), .o_tx_data(txd[1]),
        .i_tx_ready(ready[1]), .o_halt(halt[1]), .o_exit_code(code[1]));

    wb_print_fifo #(.DEPTH(4), .PACE(3), .STALL_ON_FULL(1), .SIM_PRINT(0)) u_pace (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(adr[2]), .i_wb_dat(dat[2]),
        .i_wb_we(we[2]), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]), .o_wb_rdt(rdt[2]),
        .o_wb_ack(ack[2]), .o_tx_valid(txv[2]), .o_tx_data(txd[2]),
        .i_tx_ready(ready[2]), .o_halt(halt[2]), .o_exit_code(code[2]));

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] v;
    } exp_t;

    exp_t txq[$];
    exp_t rdq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic push_tx(input int id, input logic [7:0] b);
        exp_t e;
        e.id = 2'(id);
        e.v  = {24'h0, b};
        txq.push_back(e);
    endtask

    // Monitor: compare every stream beat and every read ack against the queues.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (txv[i] && ready[i]) begin
                    if (txq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_unexpected inst=%0d actual=0x%02h required=none", i, txd[i]);
                    end else begin
                        e = txq.pop_front();
                        check("tx_beat", {22'h0, 2'(i), txd[i]}, {22'h0, e.id, e.v[7:0]});
                    end
                end
                if (ack[i] && !we[i]) begin
                    if (rdq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rd_unexpected inst=%0d actual=0x%08h required=none", i, rdt[i]);
                    end else begin
                        e = rdq.pop_front();
                        check("rd_data", rdt[i], e.v);
                        check("rd_inst", 32'(i), 32'(e.id));
                    end
                end
            end
        end
    end

    // One Wishbone cycle, entered and left at posedge+1; lat counts edges to ack.
    task automatic bus(input int id, input logic w, input logic [1:0] a,
                       input logic [31:0] d, input string name);
        int lat;
        lat = 0;
        adr[id] = a; dat[id] = d; we[id] = w; cyc[id] = 1'b1; stb[id] = 1'b1;
        @(posedge clk);
        do begin
            @(negedge clk);
            lat++;
        end while (!ack[id] && lat < 40);
        check({name, "_ack_lat"}, 32'(lat), 32'd1);
        @(posedge clk);
        #1;
        cyc[id] = 1'b0; stb[id] = 1'b0; we[id] = 1'b0;
    endtask

    task automatic wr(input int id, input logic [1:0] a, input logic [31:0] d, input string name);
        bus(id, 1'b1, a, d, name);
    endtask

    task automatic rd(input int id, input logic [1:0] a, input logic [31:0] expv, input string name);
        exp_t e;
        e.id = 2'(id);
        e.v  = expv;
        rdq.push_back(e);
        bus(id, 1'b0, a, 32'h0, name);
    endtask

    // Wait (bounded) for all queued bytes, then a few idle cycles to catch extras.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (txq.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        check({name, "_drained"}, 32'(txq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] pat;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            adr[i] = 2'd0; dat[i] = 32'h0; we[i] = 1'b0;
            cyc[i] = 1'b0; stb[i] = 1'b0; ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("rst_ack",  32'(ack[i]),  32'd0);
            check("rst_rdt",  rdt[i],       32'd0);
            check("rst_txv",  32'(txv[i]),  32'd0);
            check("rst_txd",  32'(txd[i]),  32'd0);
            check("rst_halt", 32'(halt[i]), 32'd0);
            check("rst_code", 32'(code[i]), 32'd0);
        end
        @(posedge clk);
        #1;

        // 'H','i' through the stream, then empty STATUS and zero-reading registers
        ready[0] = 1'b1;
        push_tx(0, 8'h48); wr(0, 2'd0, 32'h0000_0048, "hi_h");
        push_tx(0, 8'h69); wr(0, 2'd0, 32'h0000_0069, "hi_i");
        rd(0, 2'd1, 32'h0001_0000, "hi_status");
        rd(0, 2'd0, 32'h0000_0000, "data_read");
        wr(0, 2'd3, 32'hFFFF_FFFF, "adr3_write");
        rd(0, 2'd3, 32'h0000_0000, "adr3_read");
        drain("hi");

        // Stall on full: 4 accepted, 5th ack waits for the first pop
        ready[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_tx(0, 8'hA0 + 8'(k));
            wr(0, 2'd0, 32'h0000_00A0 + 32'(k), "stall_fill");
        end
        rd(0, 2'd1, 32'h0002_0004, "stall_status_full");
        push_tx(0, 8'hA4);
        adr[0] = 2'd0; dat[0] = 32'h0000_00A4; we[0] = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_ack_withheld", 32'(ack[0]), 32'd0);
        end
        @(posedge clk);
        #1 ready[0] = 1'b1;
        @(negedge clk);
        check("stall_ack_before_pop", 32'(ack[0]), 32'd0);
        @(negedge clk);
        check("stall_ack_after_pop", 32'(ack[0]), 32'd1);
        @(posedge clk);
        #1;
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        drain("stall");
        rd(0, 2'd1, 32'h0001_0000, "stall_status_end");

        // Drop on full: 5 acks, overflow set, only 4 bytes streamed
        ready[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_tx(1, 8'hB0 + 8'(k));
            wr(1, 2'd0, 32'h0000_00B0 + 32'(k), "drop_fill");
        end
        wr(1, 2'd0, 32'h0000_00B4, "drop_fifth");
        rd(1, 2'd1, 32'h0006_0004, "drop_status_ovf");
        wr(1, 2'd1, 32'h0004_0000, "drop_ovf_clear");
        rd(1, 2'd1, 32'h0002_0004, "drop_status_clr");
        ready[1] = 1'b1;
        drain("drop");
        rd(1, 2'd1, 32'h0001_0000, "drop_status_end");

        // PACE=3: valid pattern 1000 repeating over three queued bytes
        ready[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_tx(2, 8'h31 + 8'(k));
            wr(2, 2'd0, 32'h0000_0031 + 32'(k), "pace_fill");
        end
        ready[2] = 1'b1;
        pat = 12'b1000_1000_1000;
        for (int c = 11; c >= 0; c--) begin
            @(negedge clk);
            check("pace_valid", 32'(txv[2]), 32'(pat[c]));
        end
        drain("pace");

        // EXIT: first write wins
        check("exit_pre_halt", 32'(halt[0]), 32'd0);
        wr(0, 2'd2, 32'h0000_002A, "exit_first");
        check("exit_halt", 32'(halt[0]), 32'd1);
        check("exit_code", 32'(code[0]), 32'h2A);
        wr(0, 2'd2, 32'h0000_0007, "exit_second");
        check("exit_halt_kept", 32'(halt[0]), 32'd1);
        check("exit_code_kept", 32'(code[0]), 32'h2A);

        // Asynchronous reset mid-stream
        ready[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_tx(0, 8'h51 + 8'(k));
            wr(0, 2'd0, 32'h0000_0051 + 32'(k), "rst_fill");
        end
        check("rst_mid_valid_before", 32'(txv[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid_async", 32'(txv[0]), 32'd0);
        check("rst_mid_halt_async", 32'(halt[0]), 32'd0);
        txq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        ready[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rd(0, 2'd1, 32'h0001_0000, "rst_status");
        check("rst_halt_after", 32'(halt[0]), 32'd0);
        check("rst_code_after", 32'(code[0]), 32'd0);
        check("rd_queue_empty", 32'(rdq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
